bus_interconnect: RTL and testbench



---
 rtl/bus_interconnect.sv | 156 +++++++++++++++
 tb/tb_bus_interconnect.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
// Single-master, N-slave memory-mapped interconnect with registered request capture,
// per-slave acknowledge, timeout watchdog, sticky decode/timeout error reporting.
module bus_interconnect #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SEL_LSB        = 28,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [31:0]              address_i,
  input  logic [31:0]              write_data_i,
  output logic [31:0]              read_data_o,
  output logic                     response_o,
  output logic [NUM_SLAVES-1:0]    slave_read_o,
  output logic [NUM_SLAVES-1:0]    slave_write_o,
  output logic [31:0]              slave_address_o,
  output logic [31:0]              slave_write_data_o,
  input  logic [32*NUM_SLAVES-1:0] slave_read_data_i,
  input  logic [NUM_SLAVES-1:0]    slave_ack_i,
  output logic                     bus_error_o,
  output logic [31:0]              error_address_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccess  = 2'd1;
  localparam logic [1:0] StRespond = 2'd2;
  localparam logic [1:0] StError   = 2'd3;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [3:0]  req_sel;
  logic        req_valid;
  logic [31:0] sel_rdata;
  logic        sel_ack;

  assign req_sel   = address_i[SEL_LSB +: 4];
  assign req_valid = ({1'b0, req_sel} < 5'(NUM_SLAVES));

  // Only the selected slave's data and ack are visible to the FSM.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == 4'(i)) begin
        sel_rdata = slave_read_data_i[32*i +: 32];
        sel_ack   = slave_ack_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    bus_error_d = bus_error_q;
    err_addr_d  = err_addr_q;

    case (state_q)
      StIdle: begin
        if (read_i || write_i) begin
          addr_d  = address_i;
          wdata_d = write_data_i;
          wr_d    = write_i;
          sel_d   = req_sel;
          cnt_d   = '0;
          if (req_valid) begin
            state_d = StAccess;
          end else begin
            state_d     = StError;
            rdata_d     = write_i ? 32'h0 : ERROR_DATA;
            bus_error_d = 1'b1;
            if (!bus_error_q) err_addr_d = address_i;
          end
        end
      end
      StAccess: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (sel_ack) begin
          state_d = StRespond;
          rdata_d = wr_q ? 32'h0 : sel_rdata;
        end else if (cnt_q >= TimeoutLast) begin
          state_d     = StError;
          rdata_d     = wr_q ? 32'h0 : ERROR_DATA;
          bus_error_d = 1'b1;
          if (!bus_error_q) err_addr_d = addr_q;
        end
      end
      StRespond: state_d = StIdle;
      StError:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Strobes and response decode from state so an async reset drops them at once.
  always_comb begin
    slave_read_o  = '0;
    slave_write_o = '0;
    if (state_q == StAccess) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q == 4'(i)) begin
          slave_write_o[i] = wr_q;
          slave_read_o[i]  = !wr_q;
        end
      end
    end
  end

  assign response_o         = (state_q == StRespond) || (state_q == StError);
  assign read_data_o        = rdata_q;
  assign slave_address_o    = addr_q;
  assign slave_write_data_o = wdata_q;
  assign bus_error_o        = bus_error_q;
  assign error_address_o    = err_addr_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: expectations are queued at request time and
// checked against the DUT when its response pulse appears.
module tb_bus_interconnect;

  localparam int unsigned NS  = 4;
  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              read, write;
  logic [31:0]       address, write_data;
  logic [31:0]       read_data;
  logic              response;
  logic [NS-1:0]     slave_read, slave_write;
  logic [31:0]       slave_address, slave_write_data;
  logic [32*NS-1:0]  slave_read_data;
  logic [NS-1:0]     slave_ack;
  logic              bus_error;
  logic [31:0]       error_address;

  always #5 clk = ~clk;

  bus_interconnect #(
    .NUM_SLAVES    (NS),
    .SEL_LSB       (28),
    .TIMEOUT_CYCLES(TMO),
    .ERROR_DATA    (ERR_DATA)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .read_i            (read),
    .write_i           (write),
    .address_i         (address),
    .write_data_i      (write_data),
    .read_data_o       (read_data),
    .response_o        (response),
    .slave_read_o      (slave_read),
    .slave_write_o     (slave_write),
    .slave_address_o   (slave_address),
    .slave_write_data_o(slave_write_data),
    .slave_read_data_i (slave_read_data),
    .slave_ack_i       (slave_ack),
    .bus_error_o       (bus_error),
    .error_address_o   (error_address)
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          strobes;
    logic [3:0]  mask;
    logic [1:0]  kind;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_err_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ack_wait < 0 means the selected slave never acknowledges; stray < 0 means no stray ack.
  task automatic run(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int ack_wait, input logic [31:0] sdata,
                     input int stray);
    int          sel;
    bit          valid, tmo, err, done, wd_ok, ack_set;
    int          strobes, lat;
    logic [3:0]  or_mask;
    logic [1:0]  kind;
    exp_t        e, got;
    sel   = int'(addr[31:28]);
    valid = (sel < NS);
    tmo   = valid && (ack_wait < 0);
    err   = !valid || tmo;
    e.lat     = !valid ? 1 : (tmo ? TMO + 1 : ack_wait + 2);
    e.strobes = !valid ? 0 : (tmo ? TMO : ack_wait + 1);
    e.mask    = valid ? (4'b0001 << sel) : 4'b0000;
    e.kind    = {valid && wr, valid && !wr};
    e.rdata   = wr ? 32'h0 : (err ? ERR_DATA : sdata);
    if (err) begin
      if (!exp_err) exp_err_addr = addr;
      exp_err = 1'b1;
    end
    sb.push_back(e);

    @(negedge clk);
    read            = rd;
    write           = wr;
    address         = addr;
    write_data      = wdata;
    slave_read_data = {32'hC3C3_0003, 32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};
    if (valid) slave_read_data[32*sel +: 32] = sdata;
    slave_ack = '0;
    if (stray >= 0) slave_ack[stray] = 1'b1;
    strobes = 0; or_mask = '0; kind = '0; done = 0; wd_ok = 1; ack_set = 0; lat = 0;

    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (ack_set) begin
        slave_ack[sel] = 1'b0;
        ack_set = 0;
      end
      if ((|slave_read) || (|slave_write)) begin
        strobes++;
        or_mask = or_mask | slave_read | slave_write;
        kind    = kind | {|slave_write, |slave_read};
        if (slave_address !== addr || slave_write_data !== wdata) wd_ok = 0;
        if (valid && strobes == ack_wait + 1) begin
          slave_ack[sel] = 1'b1;
          ack_set = 1;
        end
      end
      if (response) begin
        done = 1;
        lat  = cyc;
      end
    end

    check("response_seen", 32'(done), 32'd1);
    if (done) begin
      got = sb.pop_front();
      check("latency", lat, got.lat);
      check("read_data", read_data, got.rdata);
      check("strobe_cycles", strobes, got.strobes);
      check("strobe_mask", 32'(or_mask), 32'(got.mask));
      check("strobe_kind", 32'(kind), 32'(got.kind));
      check("bus_error", 32'(bus_error), 32'(exp_err));
      check("error_address", error_address, exp_err_addr);
      if (valid) check("latched_addr_data", 32'(wd_ok), 32'd1);
      @(negedge clk);
      read = 1'b0;
      write = 1'b0;
      slave_ack = '0;
      @(posedge clk);
      #1;
      check("response_pulse_end", 32'(response), 32'd0);
      check("read_data_hold", read_data, got.rdata);
    end else begin
      void'(sb.pop_front());
      read = 1'b0;
      write = 1'b0;
      slave_ack = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    slave_read_data = '0; slave_ack = '0;
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_response", 32'(response), 32'h0);
    check("rst_strobes", 32'({slave_read, slave_write}), 32'h0);
    check("rst_slave_addr", slave_address, 32'h0);
    check("rst_slave_wdata", slave_write_data, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    check("rst_error_address", error_address, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b1, 1'b0, 32'h1000_0004, 32'h0,        0, 32'h0000_00A5, -1);
    run(1'b0, 1'b1, 32'h2000_0000, 32'h55,       3, 32'h1111_2222, -1);
    run(1'b1, 1'b1, 32'h0000_0010, 32'h1234,     2, 32'h9999_8888,  1);
    run(1'b1, 1'b0, 32'h3000_0000, 32'h0,       -1, 32'h7777_7777, -1);
    run(1'b1, 1'b0, 32'h6000_0000, 32'h0,        0, 32'h0,         -1);

    // Reset during a stalled access to slave 0.
    @(negedge clk);
    read = 1'b1; address = 32'h0000_0000;
    slave_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_strobe", 32'(slave_read), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_strobes", 32'({slave_read, slave_write}), 32'h0);
    check("async_rst_response", 32'(response), 32'h0);
    check("async_rst_bus_error", 32'(bus_error), 32'h0);
    read = 1'b0;
    @(posedge clk);
    #1;
    check("in_rst_response", 32'(response), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    exp_err_addr = 32'h0;

    run(1'b1, 1'b0, 32'h0000_0008, 32'h0,        2, 32'hCAFE_F00D, -1);
    run(1'b1, 1'b0, 32'h5000_0000, 32'h0,        0, 32'h0,         -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
